// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of single-port DataMemory: IDLE->ACCESS->RESP, one access per 3 cycles.
// Fixed priority with a starvation counter by default; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              sel;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic              gnt;
  logic              misaligned;

  assign misaligned = |addr_r[1:0];

`ifdef DMEM_ARB_RR_EN
  // ptr names the port that wins the next contested arbitration.
  logic ptr;

  assign gnt = (req0 && req1) ? ptr : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (state == IDLE && (req0 || req1)) begin
      ptr <= ~gnt;
    end
  end
`else
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  assign gnt = (req0 && req1) ? (cnt == LIMIT) : req1;

  // Counts port-0 wins over a waiting port 1; any port-1 grant or idle port 1 clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      if (!req1) begin
        cnt <= '0;
      end else if (req0 && cnt != LIMIT) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        mem_write = we_r && !misaligned;
        mem_read  = !we_r && !misaligned;
        state_nxt = RESP;
      end
      RESP: begin
        if (sel) begin
          ack1   = 1'b1;
          rdata1 = rdata_r;
          err1   = err_r;
        end else begin
          ack0   = 1'b1;
          rdata0 = rdata_r;
          err0   = err_r;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel     <= gnt;
            we_r    <= gnt ? we1 : we0;
            addr_r  <= gnt ? addr1 : addr0;
            wdata_r <= gnt ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          rdata_r <= (!we_r && !misaligned) ? mem_rdata : '0;
          err_r   <= misaligned;
        end
        default: ;
      endcase
    end
  end

endmodule
